// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared latency constants and width helper for the hazard scoreboard
package pipe_pkg;

  localparam int PIPE_MAX_LAT = 7;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = PIPE_MAX_LAT;

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MUL  = 2'd2,
    OP_DIV  = 2'd3
  } op_class_e;

  function automatic int cnt_width(input int max_lat);
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

  // Latency the control unit presents on id_lat for each producer class.
  function automatic int op_latency(input op_class_e op);
    case (op)
      OP_LOAD: return LAT_LOAD;
      OP_MUL:  return LAT_MUL;
      OP_DIV:  return LAT_DIV;
      default: return LAT_ALU;
    endcase
  endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - one register's countdown to forwardability; load beats decrement
module sb_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - per-register latency scoreboard driving ID-stage stall and flush
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 7,
  parameter int STAT_W     = 16,
  localparam int NUM_REGS  = 2 ** REG_ADDR_W,
  localparam int CW        = cnt_width(MAX_LAT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [CW-1:0]         id_lat,
  input  logic                  id_redirect,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  zero_ctrl,
  output logic                  flush,
  output logic [STAT_W-1:0]     stall_cnt
);

  localparam logic [CW:0] LAT_CAP = (CW + 1)'(MAX_LAT);

  logic [CW-1:0]     w_cnt [NUM_REGS];
  logic [CW:0]       w_lat_ext;
  logic [CW-1:0]     w_lat;
  logic              w_raw;
  logic              w_waw;
  logic              w_stall;
  logic              w_issue;
  logic [STAT_W-1:0] r_stall_cnt;

  assign w_lat_ext = {1'b0, id_lat};
  assign w_lat     = (w_lat_ext > LAT_CAP) ? LAT_CAP[CW-1:0] : id_lat;

  // $0 is hardwired so neither reads nor writes of it ever create a hazard.
  assign w_cnt[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(
      .CW(CW)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_issue & id_wr_en & (id_rd == REG_ADDR_W'(g))),
      .i_load_val (w_lat),
      .o_cnt      (w_cnt[g])
    );
  end

  // Hazards look at pre-update counts, so rd==rs compares against the old producer.
  assign w_raw   = id_valid & ((id_rs_used & (w_cnt[id_rs] != '0)) |
                               (id_rt_used & (w_cnt[id_rt] != '0)));
  assign w_waw   = id_valid & id_wr_en & (id_rd != '0) & (w_cnt[id_rd] > w_lat);
  assign w_stall = w_raw | w_waw;
  assign w_issue = id_valid & ~w_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

  assign pc_write  = ~rst | ~w_stall;
  assign ir_write  = ~rst | ~w_stall;
  assign zero_ctrl = rst & ~w_stall;
  assign flush     = rst & id_redirect & w_issue;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised hazard controller for the pipelined MIPS core. It supersedes the fixed one-cycle load-use hazard check with a per-register latency scoreboard. Each destination register carries a countdown of cycles until its result can be forwarded, so the same block handles ALU ops, loads and future multi-cycle units (mul/div) without redesign. It sits beside the ID stage and drives the PC write enable, the IF/ID write enable, the ID/EX control-zeroing select and the IF/ID flush.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W.
- MAX_LAT, 7, largest producer latency in cycles; counter width CW = $clog2(MAX_LAT+1).
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  source register addresses.
- id_rs_used, id_rt_used  in  1  the source is actually read.
- id_wr_en  in  1  the instruction writes id_rd.
- id_rd  in  REG_ADDR_W  destination register.
- id_lat  in  CW  cycles after issue before the result is forwardable (ALU 0, load 1).
- id_redirect  in  1  branch taken or jump resolved in ID.
- pc_write  out  1  PC update enable.
- ir_write  out  1  IF/ID write enable.
- zero_ctrl  out  1  1 passes control to ID/EX; 0 inserts a bubble.
- flush  out  1  clear IF/ID on the next edge.
- stall_cnt  out  STAT_W  saturating count of stall cycles.

## Operation
- State: cnt[r], CW bits, for r = 1..NUM_REGS-1. Register 0 is never tracked and always reads 0.
- raw = id_valid & ((id_rs_used & cnt[id_rs]!=0) | (id_rt_used & cnt[id_rt]!=0)).
- waw = id_valid & id_wr_en & id_rd!=0 & (cnt[id_rd] > id_lat).
- stall = raw | waw.
- issue = id_valid & ~stall.
- Outputs (combinational from state and inputs):
  - pc_write = ir_write = ~stall.
  - zero_ctrl = ~stall.
  - flush = id_redirect & issue. A redirect is acted on only when its instruction issues; while stalled, flush stays 0.
- Counter update each edge, for every r:
  - If issue & id_wr_en & id_rd==r & r!=0: cnt[r] <= id_lat. This has priority over the decrement of the same register.
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- An id_lat value above MAX_LAT is clamped to MAX_LAT.
- Reset (rst=0 at an edge):
  - All cnt and stall_cnt are cleared to 0.
  - While rst=0, outputs are pc_write=1, ir_write=1, zero_ctrl=0, flush=0, regardless of the other inputs.
  - Reset asserted mid-stall clears the stall in the same edge.

## Timing
- Zero-latency decision: stall, flush and the enables are valid in the same cycle as the ID inputs.
- A producer issued at edge t with latency L stalls any dependent consumer through cycle t+L and releases it in cycle t+L+1. Load-use therefore costs exactly one bubble; ALU-to-ALU costs none.
- A stall repeats cycle by cycle with the ID inputs held (ir_write=0), until raw and waw both clear.
- A consumer whose source equals its own destination is checked against the old cnt value, before the update.

## Structure
- Shared package pipe_pkg holds:
  - Latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3, LAT_DIV=MAX_LAT.
  - The CW width function.
- Sub-module sb_counter: one CW-bit countdown with load/decrement priority. It is instantiated NUM_REGS-1 times in a generate loop.
- The top-level control unit maps opcodes to id_lat using the pipe_pkg constants.

## Test plan
- lw $2 (lat 1), then add $3,$2,$4 -> exactly one cycle with pc_write=0, ir_write=0, zero_ctrl=0; the add issues the next cycle; stall_cnt=1.
- add $2 (lat 0), then sub using $2 -> no stall; zero_ctrl stays 1.
- mul $5 (lat 3), then a dependent add -> three stall cycles; a second mul to $5 with lat 1 while cnt[5]=3 -> waw stall until cnt[5]<=1.
- Writes to $0 with lat 7, then a consumer of $0 -> never stalls.
- beq taken (id_redirect=1) with a rs load-use hazard -> flush=0 during the stall, flush=1 on the issue cycle.
- Reset pulsed during a mul stall -> all cnt=0 and stall_cnt=0 after the edge; the next dependent instruction issues without stall; 2**STAT_W+5 forced stalls -> stall_cnt holds all-ones.
